// File: rtl/pixel_streamer_if.sv
// Memory read port and pixel stream bundle shared by pixel_streamer and its environment.
// Master side is the streamer; slave side is memory plus pixel consumer.
interface pixel_streamer_if #(
    parameter int WORD_SIZE       = 8,
    parameter int BYTES_PER_PIXEL = 3,
    parameter int ADDR_WIDTH      = 20
);
    logic                                 rd_en;
    logic [ADDR_WIDTH-1:0]                rd_addr;
    logic [WORD_SIZE-1:0]                 rd_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [WORD_SIZE*BYTES_PER_PIXEL-1:0] out_data;
    logic                                 out_sof;
    logic                                 out_eol;
    logic                                 out_eof;

    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_sof, out_eol, out_eof,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_sof, out_eol, out_eof,
        output rd_data, out_ready
    );
endinterface

// File: rtl/pixel_streamer.sv
// Fetches a padded-row frame byte by byte from memory and emits assembled pixels.
// Latency: first read the cycle after start; pixel valid BYTES_PER_PIXEL+1 cycles after its first read.
// Backpressure: pixel held stable in HOLD with no reads until out_ready; next fetch starts after handshake.
module pixel_streamer #(
    parameter int WORD_SIZE       = 8,
    parameter int BYTES_PER_PIXEL = 3,
    parameter int ADDR_WIDTH      = 20,
    parameter int DIM_WIDTH       = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  width,
    input  logic [DIM_WIDTH-1:0]  height,
    input  logic                  bottom_up,
    output logic                  busy,
    output logic                  done,
    pixel_streamer_if.master      bus
);

    localparam int KW    = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam int PW    = DIM_WIDTH + $clog2(BYTES_PER_PIXEL + 1) + 2;
    localparam int PIX_W = WORD_SIZE * BYTES_PER_PIXEL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_FINISH
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } flags_t;

    state_t                state;
    state_t                state_nxt;

    logic [DIM_WIDTH-1:0]  width_q;
    logic [DIM_WIDTH-1:0]  height_q;
    logic [DIM_WIDTH-1:0]  col_q;
    logic [DIM_WIDTH-1:0]  row_q;
    logic                  bottom_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] row_addr_q;
    logic [ADDR_WIDTH-1:0] pix_addr_q;
    logic [KW-1:0]         k_q;
    logic [WORD_SIZE-1:0]  word_buf [BYTES_PER_PIXEL];
    logic [PIX_W-1:0]      data_q;
    flags_t                flags_q;

    logic [PW-1:0]         row_bytes;
    logic [PW-1:0]         row_padded;
    logic [ADDR_WIDTH-1:0] stride_c;
    logic [DIM_WIDTH-1:0]  height_m1;
    logic [ADDR_WIDTH-1:0] first_row_addr;
    logic [ADDR_WIDTH-1:0] next_row_addr;
    logic                  last_word;
    logic                  last_col;
    logic                  last_row;
    logic                  frame_empty;

    // Rows are padded to a 4-byte multiple; bottom-up frames start at the last stored row.
    assign row_bytes      = PW'(width) * PW'(BYTES_PER_PIXEL);
    assign row_padded     = (row_bytes + PW'(3)) & ~PW'(3);
    assign stride_c       = ADDR_WIDTH'(row_padded);
    assign height_m1      = height - DIM_WIDTH'(1);
    assign first_row_addr = bottom_up ? base_addr + ADDR_WIDTH'(height_m1) * stride_c : base_addr;
    assign next_row_addr  = bottom_q ? row_addr_q - stride_q : row_addr_q + stride_q;

    assign last_word   = (k_q == KW'(BYTES_PER_PIXEL - 1));
    assign last_col    = (col_q == width_q - DIM_WIDTH'(1));
    assign last_row    = (row_q == height_q - DIM_WIDTH'(1));
    assign frame_empty = (width == '0) || (height == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.rd_en     = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = frame_empty ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                bus.rd_en = 1'b1;
                if (last_word) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = flags_q.eof ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            width_q    <= '0;
            height_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            bottom_q   <= 1'b0;
            stride_q   <= '0;
            row_addr_q <= '0;
            pix_addr_q <= '0;
            k_q        <= '0;
            data_q     <= '0;
            flags_q    <= '0;
            for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
                word_buf[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        width_q    <= width;
                        height_q   <= height;
                        bottom_q   <= bottom_up;
                        stride_q   <= stride_c;
                        row_addr_q <= first_row_addr;
                        pix_addr_q <= first_row_addr;
                        col_q      <= '0;
                        row_q      <= '0;
                        k_q        <= '0;
                    end
                end
                S_FETCH: begin
                    k_q <= last_word ? '0 : k_q + KW'(1);
                    // Read data lags the request by one cycle, so word k-1 lands while word k is requested.
                    for (int i = 0; i < BYTES_PER_PIXEL - 1; i++) begin
                        if (k_q == KW'(i + 1)) begin
                            word_buf[i] <= bus.rd_data;
                        end
                    end
                end
                S_WAIT: begin
                    for (int i = 0; i < BYTES_PER_PIXEL - 1; i++) begin
                        data_q[i*WORD_SIZE +: WORD_SIZE] <= word_buf[i];
                    end
                    data_q[(BYTES_PER_PIXEL-1)*WORD_SIZE +: WORD_SIZE] <= bus.rd_data;
                    flags_q.sof <= (col_q == '0) && (row_q == '0);
                    flags_q.eol <= last_col;
                    flags_q.eof <= last_col && last_row;
                end
                S_HOLD: begin
                    if (bus.out_ready && !flags_q.eof) begin
                        if (last_col) begin
                            col_q      <= '0;
                            row_q      <= row_q + DIM_WIDTH'(1);
                            row_addr_q <= next_row_addr;
                            pix_addr_q <= next_row_addr;
                        end else begin
                            col_q      <= col_q + DIM_WIDTH'(1);
                            pix_addr_q <= pix_addr_q + ADDR_WIDTH'(BYTES_PER_PIXEL);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rd_addr  = pix_addr_q + ADDR_WIDTH'(k_q);
    assign bus.out_data = data_q;
    assign bus.out_sof  = flags_q.sof;
    assign bus.out_eol  = flags_q.eol;
    assign bus.out_eof  = flags_q.eof;

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboarded bench for pixel_streamer: read addresses and pixels are predicted per frame and
// popped as the DUT issues reads and completes handshakes; timing relations are checked alongside.
module tb_pixel_streamer;

    localparam int W   = 8;
    localparam int BPP = 3;
    localparam int AW  = 20;
    localparam int DW  = 12;

    typedef struct packed {
        logic [W*BPP-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } px_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] width;
    logic [DW-1:0] height;
    logic          bottom_up;
    logic          busy;
    logic          done;

    pixel_streamer_if #(.WORD_SIZE(W), .BYTES_PER_PIXEL(BPP), .ADDR_WIDTH(AW)) bus ();

    pixel_streamer #(
        .WORD_SIZE(W), .BYTES_PER_PIXEL(BPP), .ADDR_WIDTH(AW), .DIM_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .width     (width),
        .height    (height),
        .bottom_up (bottom_up),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [AW-1:0] exp_addr[$];
    px_t           exp_px[$];

    int   start_cyc = 0;
    int   fetch_cyc = 0;
    int   hs_cyc = 0;
    int   done_cyc = 0;
    int   done_cnt = 0;
    bit   first_pending = 0;
    bit   prev_valid = 0;
    bit   prev_hs = 0;
    bit   prev_rd = 0;
    px_t  prev_px;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: byte at address i holds i mod 256, returned one cycle after the request.
    always @(posedge clk) bus.rd_data <= bus.rd_addr[7:0];

    // Scoreboard and timing monitor, sampled on the falling edge.
    always @(negedge clk) begin
        px_t           obs;
        px_t           ep;
        logic [AW-1:0] ea;
        bit            hs;
        obs = {bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof};
        if (reset) begin
            prev_valid = 0;
            prev_hs    = 0;
            prev_rd    = 0;
        end else begin
            hs = bus.out_valid && bus.out_ready;
            if (bus.rd_en) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    failures++;
                    $display("FAIL rd_addr: unexpected read at %h, none expected", bus.rd_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    if (bus.rd_addr !== ea) begin
                        failures++;
                        $display("FAIL rd_addr: got %h want %h (cycle %0d)", bus.rd_addr, ea, cyc);
                    end
                end
            end
            if (bus.rd_en && !prev_rd) begin
                fetch_cyc = cyc;
                checks++;
                if (first_pending) begin
                    first_pending = 0;
                    if (cyc != start_cyc + 1) begin
                        failures++;
                        $display("FAIL first_rd_latency: got cycle %0d want %0d", cyc, start_cyc + 1);
                    end
                end else if (!prev_hs) begin
                    failures++;
                    $display("FAIL fetch_after_handshake: fetch at %0d, last handshake %0d", cyc, hs_cyc);
                end
            end
            if (!bus.rd_en && prev_rd) begin
                checks++;
                if (cyc - fetch_cyc != BPP) begin
                    failures++;
                    $display("FAIL rd_burst_len: got %0d want %0d", cyc - fetch_cyc, BPP);
                end
            end
            if (bus.out_valid && !prev_valid) begin
                checks++;
                if (cyc - fetch_cyc != BPP + 1) begin
                    failures++;
                    $display("FAIL valid_latency: got %0d want %0d", cyc - fetch_cyc, BPP + 1);
                end
            end
            if (bus.out_valid && bus.rd_en) begin
                failures++;
                checks++;
                $display("FAIL read_in_hold: rd_en=1 while out_valid=1 at cycle %0d", cyc);
            end
            if (prev_valid && !prev_hs) begin
                checks++;
                if (!bus.out_valid || obs !== prev_px) begin
                    failures++;
                    $display("FAIL hold_stable: valid=%b px=%h want valid=1 px=%h", bus.out_valid, obs, prev_px);
                end
            end
            if (hs) begin
                hs_cyc = cyc;
                checks++;
                if (exp_px.size() == 0) begin
                    failures++;
                    $display("FAIL pixel: unexpected pixel %h", obs);
                end else begin
                    ep = exp_px.pop_front();
                    if (obs !== ep) begin
                        failures++;
                        $display("FAIL pixel: got data=%h sof/eol/eof=%b%b%b want data=%h %b%b%b",
                                 obs.data, obs.sof, obs.eol, obs.eof, ep.data, ep.sof, ep.eol, ep.eof);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_valid = bus.out_valid;
            prev_hs    = hs;
            prev_rd    = bus.rd_en;
            prev_px    = obs;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int b, input int w, input int h, input bit bu);
        base_addr     = AW'(b);
        width         = DW'(w);
        height        = DW'(h);
        bottom_up     = bu;
        start         = 1'b1;
        start_cyc     = cyc;
        first_pending = 1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_model(input int b, input int w, input int h, input bit bu);
        int            stride;
        int            srow;
        logic [AW-1:0] a;
        px_t           p;
        stride = ((w * BPP + 3) / 4) * 4;
        for (int r = 0; r < h; r++) begin
            srow = bu ? (h - 1 - r) : r;
            for (int c = 0; c < w; c++) begin
                for (int k = 0; k < BPP; k++) begin
                    a = AW'(b + srow * stride + c * BPP + k);
                    exp_addr.push_back(a);
                    p.data[k*W +: W] = a[7:0];
                end
                p.sof = (r == 0) && (c == 0);
                p.eol = (c == w - 1);
                p.eof = (c == w - 1) && (r == h - 1);
                exp_px.push_back(p);
            end
        end
    endtask

    task automatic push_ref_2x2(input bit bu);
        int a_top[6] = '{0, 1, 2, 3, 4, 5};
        int a_bot[6] = '{8, 9, 10, 11, 12, 13};
        for (int i = 0; i < 6; i++) exp_addr.push_back(AW'(bu ? a_bot[i] : a_top[i]));
        for (int i = 0; i < 6; i++) exp_addr.push_back(AW'(bu ? a_top[i] : a_bot[i]));
        if (!bu) begin
            exp_px.push_back({24'h020100, 3'b100});
            exp_px.push_back({24'h050403, 3'b010});
            exp_px.push_back({24'h0A0908, 3'b000});
            exp_px.push_back({24'h0D0C0B, 3'b011});
        end else begin
            exp_px.push_back({24'h0A0908, 3'b100});
            exp_px.push_back({24'h0D0C0B, 3'b010});
            exp_px.push_back({24'h020100, 3'b000});
            exp_px.push_back({24'h050403, 3'b011});
        end
    endtask

    task automatic recover();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_addr.delete();
        exp_px.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        width = 12'd2;
        height = 12'd2;
        tick();
        tick();
        checks++;
        if ({busy, done, bus.rd_en, bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy/done/rd_en/valid/sof/eol/eof=%b%b%b%b%b%b%b want all 0",
                     busy, done, bus.rd_en, bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof);
        end
        checks++;
        if (bus.out_data !== '0 || bus.rd_addr !== '0) begin
            failures++;
            $display("FAIL reset_data: out_data=%h rd_addr=%h want 0 0", bus.out_data, bus.rd_addr);
        end
        start = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_vs_start: busy=%b rd_en=%b want 0 0", busy, bus.rd_en);
        end
    endtask

    task automatic test_basic(input bit bu);
        int n0;
        bus.out_ready = 1'b1;
        push_ref_2x2(bu);
        n0 = done_cnt;
        kick(0, 2, 2, bu);
        tick();
        tick();
        start = 1'b1;
        width = 12'd5;
        base_addr = 20'h00400;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && done_cnt == n0; i++) tick();
        checks++;
        if (done_cnt == n0) begin
            failures++;
            $display("FAIL basic_done(bu=%0d): no done within budget", bu);
            recover();
        end else begin
            if (done_cyc != hs_cyc + 1) begin
                failures++;
                $display("FAIL basic_done_timing: done at %0d want %0d", done_cyc, hs_cyc + 1);
            end
            checks++;
            if (exp_addr.size() != 0 || exp_px.size() != 0) begin
                failures++;
                $display("FAIL basic_drain(bu=%0d): %0d reads, %0d pixels missing", bu, exp_addr.size(), exp_px.size());
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_stall();
        int  n0;
        px_t held;
        bit  seen;
        bus.out_ready = 1'b0;
        push_ref_2x2(1'b0);
        n0 = done_cnt;
        kick(0, 2, 2, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid === 1'b1) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL stall_valid: out_valid never rose");
            recover();
            return;
        end
        held = {bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.rd_en !== 1'b0 ||
                {bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof} !== held) begin
                failures++;
                $display("FAIL stall_hold[%0d]: valid=%b rd_en=%b data=%h want 1 0 %h",
                         i, bus.out_valid, bus.rd_en, bus.out_data, held.data);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== 20'd3) begin
            failures++;
            $display("FAIL stall_resume: rd_en=%b rd_addr=%h want 1 00003", bus.rd_en, bus.rd_addr);
        end
        for (int i = 0; i < 200 && done_cnt == n0; i++) tick();
        checks++;
        if (done_cnt == n0 || exp_px.size() != 0) begin
            failures++;
            $display("FAIL stall_done: done_seen=%0d pixels_left=%0d want 1 0", done_cnt - n0, exp_px.size());
            recover();
        end
        tick();
    endtask

    task automatic test_empty();
        int n0;
        n0 = done_cnt;
        kick(0, 0, 4, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b1 || bus.rd_en !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_finish: busy=%b done=%b rd_en=%b valid=%b want 1 1 0 0",
                     busy, done, bus.rd_en, bus.out_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL empty_idle: busy=%b done=%b want 0 0", busy, done);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (done_cnt != n0 + 1) begin
            failures++;
            $display("FAIL empty_done_count: got %0d pulses want 1", done_cnt - n0);
        end
    endtask

    task automatic test_wrap();
        int n0;
        bus.out_ready = 1'b1;
        exp_addr.push_back(20'hFFFFE);
        exp_addr.push_back(20'hFFFFF);
        exp_addr.push_back(20'h00000);
        exp_px.push_back({24'h00FFFE, 3'b111});
        n0 = done_cnt;
        kick(32'h000FFFFE, 1, 1, 1'b0);
        for (int i = 0; i < 50 && done_cnt == n0; i++) tick();
        checks++;
        if (done_cnt == n0 || exp_px.size() != 0 || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL wrap: done_seen=%0d reads_left=%0d pixels_left=%0d want 1 0 0",
                     done_cnt - n0, exp_addr.size(), exp_px.size());
            recover();
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n0;
        bit seen;
        bus.out_ready = 1'b0;
        push_model(0, 2, 2, 1'b0);
        kick(0, 2, 2, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid === 1'b1) seen = 1;
            else tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid === 1'b1) seen = 1;
            else tick();
        end
        checks++;
        if (!seen || bus.out_data !== 24'h050403) begin
            failures++;
            $display("FAIL rstmid_second_hold: seen=%0d data=%h want 1 050403", seen, bus.out_data);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({busy, done, bus.rd_en, bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof} !== 7'b0 ||
            bus.out_data !== '0 || bus.rd_addr !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: ctrl=%b%b%b%b%b%b%b data=%h addr=%h want all 0",
                     busy, done, bus.rd_en, bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof,
                     bus.out_data, bus.rd_addr);
        end
        reset = 1'b0;
        exp_addr.delete();
        exp_px.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.rd_en !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_quiet[%0d]: valid=%b rd_en=%b want 0 0", i, bus.out_valid, bus.rd_en);
            end
        end
        push_model(32'h100, 2, 2, 1'b0);
        n0 = done_cnt;
        kick(32'h100, 2, 2, 1'b0);
        for (int i = 0; i < 200 && done_cnt == n0; i++) tick();
        checks++;
        if (done_cnt == n0 || exp_px.size() != 0) begin
            failures++;
            $display("FAIL rstmid_restart: done_seen=%0d pixels_left=%0d want 1 0", done_cnt - n0, exp_px.size());
            recover();
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n0, b, w, h;
        bit bu;
        for (int f = 0; f < 5; f++) begin
            b  = int'($urandom_range(0, 20'hFFFFF));
            w  = int'($urandom_range(1, 5));
            h  = int'($urandom_range(1, 3));
            bu = 1'($urandom_range(0, 1));
            push_model(b, w, h, bu);
            n0 = done_cnt;
            kick(b, w, h, bu);
            for (int i = 0; i < 2000 && done_cnt == n0; i++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            checks++;
            if (done_cnt == n0 || exp_px.size() != 0 || exp_addr.size() != 0) begin
                failures++;
                $display("FAIL b2b_frame[%0d] %0dx%0d bu=%0d: done_seen=%0d reads_left=%0d pixels_left=%0d",
                         f, w, h, bu, done_cnt - n0, exp_addr.size(), exp_px.size());
                recover();
            end
            tick();
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        width         = '0;
        height        = '0;
        bottom_up     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_stall();
        test_empty();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
